// File: rtl/i2c_slv_regs.sv
// i2c_slv_regs: I2C target that models an MPU-6050-style 256 x 8 register file.
// Single and burst register writes and reads, repeated START, pointer auto-increment,
// and a write strobe so local logic can follow register updates.
// Optional macro I2C_SLV_GLITCH_FLT_EN: a 3-sample majority filter on each
// synchronized line (2 CLK extra latency, suppresses single-CLK spikes).
module i2c_slv_regs #(
    parameter logic [6:0]             SLV_ADDR      = 7'h68,
    parameter int                     DATA_I2C_SZ   = 8,
    parameter logic [7:0]             WHO_AM_I_ADDR = 8'h75,
    parameter logic [DATA_I2C_SZ-1:0] WHO_AM_I_VAL  = 8'h68,
    parameter int                     SYNC_STG      = 2
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_SCL,
    input  logic                   I_SDA,
    output logic                   O_SDA_OE,
    output logic                   O_WR_STB,
    output logic [7:0]             O_WR_ADDR,
    output logic [DATA_I2C_SZ-1:0] O_WR_DATA,
    output logic [7:0]             O_PTR,
    output logic                   O_BUSY,
    output logic                   O_ERR
);

    // Bit counter holds 0..DATA_I2C_SZ plus one marker for "master ACK seen".
    localparam int                CNT_W    = $clog2(DATA_I2C_SZ + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_I2C_SZ);
    localparam logic [CNT_W-1:0] ACK_BIT  = CNT_W'(DATA_I2C_SZ + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK, PTR, WR_DATA, RD_DATA, IGNORE
    } state_t;

    logic [SYNC_STG-1:0]    scl_sync, sda_sync;
    logic                   scl_flt, sda_flt;
    logic                   scl_q, sda_q;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det, mid_byte;
    state_t                 state, ret_state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_I2C_SZ-1:0] shreg, rd_byte;
    logic [7:0]             ptr;
    logic                   sda_oe, busy, err, wr_stb;
    logic [7:0]             wr_addr;
    logic [DATA_I2C_SZ-1:0] wr_data;
    logic [DATA_I2C_SZ-1:0] regs [256];

    // Pad synchronizers; reset to the idle-high bus level so no edge appears at reset release.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STG-2:0], I_SCL};
            sda_sync <= {sda_sync[SYNC_STG-2:0], I_SDA};
        end
    end

`ifdef I2C_SLV_GLITCH_FLT_EN
    logic [1:0] scl_hist, sda_hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority of the last three synchronized samples, registered.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_flt  <= 1'b1;
            sda_flt  <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STG-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STG-1]};
            scl_flt  <= maj3(scl_sync[SYNC_STG-1], scl_hist[0], scl_hist[1]);
            sda_flt  <= maj3(sda_sync[SYNC_STG-1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_flt = scl_sync[SYNC_STG-1];
    assign sda_flt = sda_sync[SYNC_STG-1];
`endif

    // Previous-value flops for edge detection.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_flt;
            sda_q <= sda_flt;
        end
    end

    assign scl_rise = scl_flt & ~scl_q;
    assign scl_fall = ~scl_flt & scl_q;
    assign sda_rise = sda_flt & ~sda_q;
    assign sda_fall = ~sda_flt & sda_q;

    // START/STOP need SCL steady high, so an SDA edge coincident with an SCL edge is only data.
    assign start_det = sda_fall & scl_flt & scl_q;
    assign stop_det  = sda_rise & scl_flt & scl_q;

    // A START/STOP that cuts an addressed byte short is a protocol error.
    assign mid_byte = busy && (state inside {PTR, WR_DATA, RD_DATA}) &&
                      (bit_cnt != '0) && (bit_cnt < LAST_BIT);

    assign rd_byte = (ptr == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : regs[ptr];

    // Protocol FSM: bit shifting, ACK generation, read data driving and pointer handling.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            ret_state <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (start_det) begin
                if (mid_byte) err <= 1'b1;
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                if (mid_byte) err <= 1'b1;
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WR_DATA: begin
                        if (scl_rise && (bit_cnt < LAST_BIT)) begin
                            shreg   <= {shreg[DATA_I2C_SZ-2:0], sda_flt};
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end else if (scl_fall && (bit_cnt == LAST_BIT)) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == SLV_ADDR) begin
                                    sda_oe    <= 1'b1;
                                    busy      <= 1'b1;
                                    err       <= 1'b0;
                                    ret_state <= shreg[0] ? RD_DATA : PTR;
                                    state     <= ACK;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IGNORE;
                                end
                            end else begin
                                if (state == PTR) begin
                                    ptr <= shreg[7:0];
                                end else begin
                                    wr_stb  <= 1'b1;
                                    wr_addr <= ptr;
                                    wr_data <= shreg;
                                    ptr     <= ptr + 8'd1;
                                end
                                sda_oe    <= 1'b1;
                                ret_state <= WR_DATA;
                                state     <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            state   <= ret_state;
                            if (ret_state == RD_DATA) begin
                                shreg  <= rd_byte;
                                sda_oe <= ~rd_byte[DATA_I2C_SZ-1];
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            if (bit_cnt == LAST_BIT) begin
                                // The byte has been clocked out, so the pointer moves on either way.
                                ptr <= ptr + 8'd1;
                                if (sda_flt) begin
                                    busy  <= 1'b0;
                                    state <= IGNORE;
                                end else begin
                                    bit_cnt <= ACK_BIT;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_ONE;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == ACK_BIT) begin
                                shreg   <= rd_byte;
                                sda_oe  <= ~rd_byte[DATA_I2C_SZ-1];
                                bit_cnt <= '0;
                            end else if (bit_cnt == LAST_BIT) begin
                                sda_oe <= 1'b0;
                            end else begin
                                shreg  <= shreg << 1;
                                sda_oe <= ~shreg[DATA_I2C_SZ-2];
                            end
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Register file update one CLK after the strobe; the ID location is read-only.
    // NOTE: the register file has defined reset contents, so it is reset here like the control state.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < 256; i++) regs[i] <= '0;
        end else if (wr_stb && (wr_addr != WHO_AM_I_ADDR)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign O_SDA_OE  = sda_oe;
    assign O_WR_STB  = wr_stb;
    assign O_WR_ADDR = wr_addr;
    assign O_WR_DATA = wr_data;
    assign O_PTR     = ptr;
    assign O_BUSY    = busy;
    assign O_ERR     = err;

endmodule

// File: tb/tb_i2c_slv_regs.sv
// Directed bench for i2c_slv_regs: a bit-banged I2C master with a write/read scoreboard.
module tb_i2c_slv_regs;

    localparam int Q = 8;  // quarter bit period in CLK cycles

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       sda_line;
    logic       O_SDA_OE, O_WR_STB, O_BUSY, O_ERR;
    logic [7:0] O_WR_ADDR, O_WR_DATA, O_PTR;

    int         total = 0;
    int         passed = 0;
    int         failed = 0;
    int         oe_cycles = 0;
    wr_t        obs_wr[$];
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] model [256];
    logic [7:0] exp_ptr = 8'h00;

    assign sda_line = ~(m_sda_low | O_SDA_OE);

    always #5 CLK = ~CLK;

    i2c_slv_regs dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .I_SCL     (scl),
        .I_SDA     (sda_line),
        .O_SDA_OE  (O_SDA_OE),
        .O_WR_STB  (O_WR_STB),
        .O_WR_ADDR (O_WR_ADDR),
        .O_WR_DATA (O_WR_DATA),
        .O_PTR     (O_PTR),
        .O_BUSY    (O_BUSY),
        .O_ERR     (O_ERR)
    );

    // Collect every write strobe and count cycles with SDA pulled low.
    always @(negedge CLK) begin
        if (O_WR_STB) obs_wr.push_back('{O_WR_ADDR, O_WR_DATA});
        if (O_SDA_OE) oe_cycles++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus_start();
        if (!scl) begin
            tick(Q); m_sda_low = 1'b0;
            tick(Q); scl = 1'b1;
            tick(Q);
        end else begin
            m_sda_low = 1'b0;
            tick(Q);
        end
        m_sda_low = 1'b1;
        tick(Q); scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(Q); m_sda_low = 1'b1;
        tick(Q); scl = 1'b1;
        tick(Q); m_sda_low = 1'b0;
        tick(2 * Q);
    endtask

    // One bit cycle starting just after SCL fell; returns the line level at mid-high.
    task automatic bus_bit(input logic b, output logic s);
        tick(Q); m_sda_low = ~b;
        tick(Q); scl = 1'b1;
        tick(Q); s = sda_line;
        tick(Q); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    task automatic m_addr(input logic [6:0] a, input logic rw, input logic exp_ack, input string tag);
        logic ack;
        send_byte({a, rw}, ack);
        check(tag, ack, exp_ack);
    endtask

    task automatic m_ptr(input logic [7:0] p);
        logic ack;
        send_byte(p, ack);
        check("ptr_ack", ack, 1'b1);
        exp_ptr = p;
    endtask

    task automatic m_write(input logic [7:0] d);
        logic ack;
        send_byte(d, ack);
        check("wr_ack", ack, 1'b1);
        exp_wr.push_back('{exp_ptr, d});
        if (exp_ptr != 8'h75) model[exp_ptr] = d;
        exp_ptr = exp_ptr + 8'd1;
    endtask

    task automatic m_read(input logic mack, input string tag);
        logic [7:0] got;
        exp_rd.push_back((exp_ptr == 8'h75) ? 8'h68 : model[exp_ptr]);
        exp_ptr = exp_ptr + 8'd1;
        read_byte(mack, got);
        check(tag, got, exp_rd.pop_front());
    endtask

    task automatic check_writes(input string tag);
        wr_t o, e;
        check({tag, "_cnt"}, obs_wr.size(), exp_wr.size());
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            check({tag, "_addr"}, o.addr, e.addr);
            check({tag, "_data"}, o.data, e.data);
        end
        obs_wr.delete();
        exp_wr.delete();
    endtask

    // Write-pointer, repeated START, read-address prefix of every register read.
    task automatic read_prefix(input logic [7:0] p);
        bus_start();
        m_addr(7'h68, 1'b0, 1'b1, "addr_w_ack");
        m_ptr(p);
        bus_start();
        m_addr(7'h68, 1'b1, 1'b1, "addr_r_ack");
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        // Reset state
        tick(5);
        check("rst_oe", O_SDA_OE, 1'b0);
        check("rst_stb", O_WR_STB, 1'b0);
        check("rst_wr_addr", O_WR_ADDR, 8'h00);
        check("rst_wr_data", O_WR_DATA, 8'h00);
        check("rst_ptr", O_PTR, 8'h00);
        check("rst_busy", O_BUSY, 1'b0);
        check("rst_err", O_ERR, 1'b0);
        RST_n = 1'b1;
        tick(10);

        // Single write: ptr 6B, data 00
        bus_start();
        m_addr(7'h68, 1'b0, 1'b1, "addr_w_ack");
        check("busy_after_match", O_BUSY, 1'b1);
        m_ptr(8'h6B);
        m_write(8'h00);
        bus_stop();
        check("busy_after_stop", O_BUSY, 1'b0);
        check_writes("single_wr");
        check("ptr_single", O_PTR, exp_ptr);

        // WHO_AM_I read with master NACK
        read_prefix(8'h75);
        m_read(1'b0, "whoami_rd");
        tick(2);
        check("oe_released_after_nack", O_SDA_OE, 1'b0);
        check("busy_after_nack", O_BUSY, 1'b0);
        bus_stop();

        // Write to WHO_AM_I is ACKed and strobed but ignored
        bus_start();
        m_addr(7'h68, 1'b0, 1'b1, "addr_w_ack");
        m_ptr(8'h75);
        m_write(8'h12);
        bus_stop();
        check_writes("whoami_wr");
        read_prefix(8'h75);
        m_read(1'b0, "whoami_readback");
        bus_stop();

        // Burst write and read-back
        bus_start();
        m_addr(7'h68, 1'b0, 1'b1, "addr_w_ack");
        m_ptr(8'h3B);
        m_write(8'hA1);
        m_write(8'hB2);
        m_write(8'hC3);
        bus_stop();
        check_writes("burst_wr");
        read_prefix(8'h3B);
        m_read(1'b1, "burst_rd0");
        m_read(1'b1, "burst_rd1");
        m_read(1'b0, "burst_rd2");
        bus_stop();
        check("ptr_after_burst", O_PTR, 8'h3E);

        // Pointer wrap FF -> 00
        bus_start();
        m_addr(7'h68, 1'b0, 1'b1, "addr_w_ack");
        m_ptr(8'hFF);
        m_write(8'h11);
        m_write(8'h22);
        bus_stop();
        check_writes("wrap_wr");
        check("ptr_after_wrap", O_PTR, 8'h01);
        read_prefix(8'hFF);
        m_read(1'b1, "wrap_rd_ff");
        m_read(1'b0, "wrap_rd_00");
        bus_stop();

        // Foreign address 69: no ACK, no drive, no write, not busy
        snap = oe_cycles;
        bus_start();
        m_addr(7'h69, 1'b0, 1'b0, "addr69_nack");
        check("addr69_busy", O_BUSY, 1'b0);
        m_addr(7'h2A, 1'b1, 1'b0, "addr69_byte2_nack");
        bus_stop();
        check("addr69_oe_cycles", oe_cycles - snap, 0);
        check_writes("addr69_wr");

        // STOP after 4 data bits: error, no write; next match clears the error
        bus_start();
        m_addr(7'h68, 1'b0, 1'b1, "addr_w_ack");
        m_ptr(8'h10);
        begin
            logic s;
            bus_bit(1'b1, s);
            bus_bit(1'b0, s);
            bus_bit(1'b1, s);
            bus_bit(1'b1, s);
        end
        bus_stop();
        check("err_after_short_stop", O_ERR, 1'b1);
        check("busy_after_short_stop", O_BUSY, 1'b0);
        check_writes("short_wr");
        read_prefix(8'h10);
        check("err_cleared_by_match", O_ERR, 1'b0);
        m_read(1'b0, "short_wr_reg_untouched");
        bus_stop();

        // Reset during a read bit releases SDA at once
        read_prefix(8'h75);
        tick(Q);
        check("oe_driving_read_bit", O_SDA_OE, 1'b1);
        RST_n = 1'b0;
        #1;
        check("oe_async_reset", O_SDA_OE, 1'b0);
        tick(2);
        check("ptr_reset", O_PTR, 8'h00);
        check("busy_reset", O_BUSY, 1'b0);
        scl = 1'b1;
        m_sda_low = 1'b0;
        tick(4);
        RST_n = 1'b1;
        tick(10);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        read_prefix(8'h3B);
        m_read(1'b0, "reg_cleared_by_reset");
        bus_stop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
